// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: in-order request/response.
interface fetch_stage_if;
   logic        IMEM_REQ_V;
   logic        IMEM_REQ_RDY;
   logic [63:0] IMEM_ADDR;
   logic        IMEM_RESP_V;
   logic [31:0] IMEM_RESP_DATA;

   modport master (
      output IMEM_REQ_V,
      output IMEM_ADDR,
      input  IMEM_REQ_RDY,
      input  IMEM_RESP_V,
      input  IMEM_RESP_DATA
   );

   modport slave (
      input  IMEM_REQ_V,
      input  IMEM_ADDR,
      output IMEM_REQ_RDY,
      output IMEM_RESP_V,
      output IMEM_RESP_DATA
   );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, credit-limited instruction fetch, small instruction buffer,
// decode latch and branch/trap redirect with stale-response dropping.
module fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic          CLK,
   input  logic          reset,
   fetch_stage_if.master imem,
   input  logic          DE_STALL,
   input  logic          BR_STALL,
   input  logic          BR_TAKEN,
   input  logic [63:0]   BR_TARGET,
   input  logic          TRAP,
   input  logic [63:0]   MTVEC,
   output logic [63:0]   DE_NPC,
   output logic [31:0]   DE_IR,
   output logic          DE_V
);

   localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

   // Architectural state
   logic [63:0]     r_pc;
   logic [CntW-1:0] r_inflight;
   logic [CntW-1:0] r_drop_cnt;
   logic [CntW-1:0] r_count;

   // Instruction buffer: {tag PC, instruction word}
   logic [63:0]     r_buf_pc [BUF_DEPTH];
   logic [31:0]     r_buf_ir [BUF_DEPTH];
   logic [PtrW-1:0] r_rd_ptr;
   logic [PtrW-1:0] r_wr_ptr;

   // Tag FIFO: PC of each live (non-dropped) request, in issue order
   logic [63:0]     r_tag [BUF_DEPTH];
   logic [PtrW-1:0] r_tag_rd;
   logic [PtrW-1:0] r_tag_wr;

   logic            w_redirect;
   logic [63:0]     w_redir_pc;
   logic            w_credit;
   logic            w_req_v;
   logic            w_accept;
   logic            w_drop;
   logic            w_push;
   logic            w_pop;
   logic [CntW-1:0] w_inflight_d;
   logic [CntW-1:0] w_drop_d;
   logic [CntW-1:0] w_count_d;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(BUF_DEPTH - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   assign w_redirect = TRAP | BR_TAKEN;
   assign w_redir_pc = (TRAP ? MTVEC : BR_TARGET) & ~64'h3;
   // Requests in flight plus buffered entries never exceed the buffer size,
   // so every live response is guaranteed a free slot.
   assign w_credit   = ({1'b0, r_inflight} + {1'b0, r_count}) < {1'b0, Depth};
   assign w_req_v    = !reset && !w_redirect && w_credit;
   assign w_accept   = w_req_v && imem.IMEM_REQ_RDY;
   assign w_drop     = imem.IMEM_RESP_V && (r_drop_cnt != '0);
   assign w_push     = !reset && !w_redirect && imem.IMEM_RESP_V && (r_drop_cnt == '0);
   assign w_pop      = !w_redirect && !DE_STALL && !BR_STALL && (r_count != '0);

   assign imem.IMEM_REQ_V = w_req_v;
   assign imem.IMEM_ADDR  = r_pc;

   // Next-state counters for in-flight requests, stale responses and buffer occupancy
   always_comb begin
      w_inflight_d = r_inflight + CntW'(w_accept) - CntW'(imem.IMEM_RESP_V);
      w_count_d    = r_count + CntW'(w_push) - CntW'(w_pop);
      w_drop_d     = r_drop_cnt - CntW'(w_drop);
      if (w_redirect) begin
         // Everything still owed after this cycle belongs to the old path.
         w_drop_d = r_inflight - CntW'(imem.IMEM_RESP_V);
      end
   end

   // PC, counters and buffer/tag pointers
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_tag_rd   <= '0;
         r_tag_wr   <= '0;
      end else begin
         r_inflight <= w_inflight_d;
         r_drop_cnt <= w_drop_d;
         if (w_redirect) begin
            r_pc     <= w_redir_pc;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_tag_rd <= '0;
            r_tag_wr <= '0;
         end else begin
            r_count <= w_count_d;
            if (w_accept) begin
               r_pc     <= r_pc + 64'd4;
               r_tag_wr <= ptr_inc(r_tag_wr);
            end
            if (w_push) begin
               r_wr_ptr <= ptr_inc(r_wr_ptr);
               r_tag_rd <= ptr_inc(r_tag_rd);
            end
            if (w_pop) begin
               r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
         end
      end
   end

   // Tag and buffer storage; validity is tracked by the pointers above
   always_ff @(posedge CLK) begin
      if (w_accept) begin
         r_tag[r_tag_wr] <= r_pc;
      end
      if (w_push) begin
         r_buf_pc[r_wr_ptr] <= r_tag[r_tag_rd];
         r_buf_ir[r_wr_ptr] <= imem.IMEM_RESP_DATA;
      end
   end

   // Decode latch: redirect kills, stall holds, bubble when nothing to issue
   always_ff @(posedge CLK) begin
      if (reset) begin
         DE_V   <= 1'b0;
         DE_IR  <= '0;
         DE_NPC <= '0;
      end else if (w_redirect) begin
         DE_V <= 1'b0;
      end else if (DE_STALL) begin
         DE_V <= DE_V;
      end else if (BR_STALL || (r_count == '0)) begin
         DE_V <= 1'b0;
      end else begin
         DE_V   <= 1'b1;
         DE_IR  <= r_buf_ir[r_rd_ptr];
         DE_NPC <= r_buf_pc[r_rd_ptr] + 64'd4;
      end
   end

   // A live response must always find a free slot (pop frees one first)
   always_ff @(posedge CLK) begin
      if (!reset) begin
         assert (!(w_push && !w_pop && (r_count == Depth)));
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle in-order memory model.
module tb_fetch_stage;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        CLK = 1'b0;
   logic        reset;
   logic        DE_STALL;
   logic        BR_STALL;
   logic        BR_TAKEN;
   logic [63:0] BR_TARGET;
   logic        TRAP;
   logic [63:0] MTVEC;
   logic [63:0] DE_NPC;
   logic [31:0] DE_IR;
   logic        DE_V;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] pend[$];
   logic        resp_en;

   fetch_stage_if imem_if ();

   fetch_stage #(
      .RESET_PC (RESET_PC),
      .BUF_DEPTH(2)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .imem     (imem_if),
      .DE_STALL (DE_STALL),
      .BR_STALL (BR_STALL),
      .BR_TAKEN (BR_TAKEN),
      .BR_TARGET(BR_TARGET),
      .TRAP     (TRAP),
      .MTVEC    (MTVEC),
      .DE_NPC   (DE_NPC),
      .DE_IR    (DE_IR),
      .DE_V     (DE_V)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory: accept seen before edge k, respond in the cycle ending at edge k+1
   always begin : mem_model
      logic [63:0] a;
      @(negedge CLK);
      #2;
      if (reset) begin
         pend.delete();
         imem_if.IMEM_RESP_V    = 1'b0;
         imem_if.IMEM_RESP_DATA = '0;
      end else begin
         if (resp_en && pend.size() > 0) begin
            a = pend.pop_front();
            imem_if.IMEM_RESP_V    = 1'b1;
            imem_if.IMEM_RESP_DATA = mem_word(a);
         end else begin
            imem_if.IMEM_RESP_V = 1'b0;
         end
         if (imem_if.IMEM_REQ_V && imem_if.IMEM_REQ_RDY) pend.push_back(imem_if.IMEM_ADDR);
      end
   end

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      imem_if.IMEM_REQ_RDY = 1'b1;
      DE_STALL = 1'b0; BR_STALL = 1'b0; BR_TAKEN = 1'b0; TRAP = 1'b0;
      BR_TARGET = '0; MTVEC = '0; resp_en = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      imem_if.IMEM_REQ_RDY = 1'b1;
      imem_if.IMEM_RESP_V = 1'b0;
      imem_if.IMEM_RESP_DATA = '0;
      DE_STALL = 1'b0; BR_STALL = 1'b0; BR_TAKEN = 1'b0; TRAP = 1'b0;
      BR_TARGET = '0; MTVEC = '0; resp_en = 1'b1;
      cyc();
      cyc();
      n_cmp++; if (DE_V !== 1'b0) begin n_bad++; $display("FAIL reset_de_v: got %b want 0", DE_V); end
      n_cmp++; if (DE_IR !== 32'h0) begin n_bad++; $display("FAIL reset_de_ir: got %h want 0", DE_IR); end
      n_cmp++; if (DE_NPC !== 64'h0) begin n_bad++; $display("FAIL reset_de_npc: got %h want 0", DE_NPC); end
      n_cmp++; if (imem_if.IMEM_REQ_V !== 1'b0) begin n_bad++; $display("FAIL reset_req_v: got %b want 0", imem_if.IMEM_REQ_V); end
      n_cmp++; if (imem_if.IMEM_ADDR !== RESET_PC) begin n_bad++; $display("FAIL reset_addr: got %h want %h", imem_if.IMEM_ADDR, RESET_PC); end
   endtask

   // Continues from test_reset: start-up latency and first deliveries
   task automatic test_stream();
      logic [5:0]  ev;
      logic [63:0] en [6];
      ev = 6'b101100;
      en = '{64'h0, 64'h0, 64'h4, 64'h8, 64'h0, 64'hC};
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         cyc();
         n_cmp++;
         if (DE_V !== ev[c]) begin n_bad++; $display("FAIL stream_v[%0d]: got %b want %b", c + 1, DE_V, ev[c]); end
         if (ev[c]) begin
            n_cmp++;
            if (DE_IR !== mem_word(en[c] - 64'd4) || DE_NPC !== en[c]) begin
               n_bad++;
               $display("FAIL stream_de[%0d]: got %h/%h want %h/%h", c + 1, DE_IR, DE_NPC, mem_word(en[c] - 64'd4), en[c]);
            end
         end
         if (c == 0) begin
            n_cmp++; if (imem_if.IMEM_ADDR !== 64'h4) begin n_bad++; $display("FAIL stream_addr1: got %h want 4", imem_if.IMEM_ADDR); end
         end
         if (c == 1) begin
            n_cmp++;
            if (imem_if.IMEM_ADDR !== 64'h8 || imem_if.IMEM_REQ_V !== 1'b0) begin
               n_bad++; $display("FAIL stream_credit: got addr %h req %b want 8/0", imem_if.IMEM_ADDR, imem_if.IMEM_REQ_V);
            end
         end
      end
   endtask

   // Continues from test_stream with I2 in decode and I3 buffered
   task automatic test_de_stall();
      logic [3:0]  ev;
      logic [63:0] en [4];
      ev = 4'b1011;
      en = '{64'h10, 64'h14, 64'h0, 64'h18};
      DE_STALL = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc();
         n_cmp++;
         if (DE_V !== 1'b1 || DE_IR !== mem_word(64'h8) || DE_NPC !== 64'hC) begin
            n_bad++; $display("FAIL stall_hold[%0d]: got %b %h/%h want 1 %h/c", c, DE_V, DE_IR, DE_NPC, mem_word(64'h8));
         end
         n_cmp++;
         if (imem_if.IMEM_REQ_V !== 1'b0) begin n_bad++; $display("FAIL stall_req_v[%0d]: got %b want 0", c, imem_if.IMEM_REQ_V); end
      end
      DE_STALL = 1'b0;
      for (int c = 0; c < 4; c++) begin
         cyc();
         n_cmp++;
         if (DE_V !== ev[c]) begin n_bad++; $display("FAIL stall_rel_v[%0d]: got %b want %b", c, DE_V, ev[c]); end
         if (ev[c]) begin
            n_cmp++;
            if (DE_IR !== mem_word(en[c] - 64'd4) || DE_NPC !== en[c]) begin
               n_bad++; $display("FAIL stall_rel_de[%0d]: got %h/%h want %h/%h", c, DE_IR, DE_NPC, mem_word(en[c] - 64'd4), en[c]);
            end
         end
      end
   endtask

   task automatic test_br_stall();
      do_reset();
      cyc(); cyc(); cyc();
      n_cmp++;
      if (DE_V !== 1'b1 || DE_NPC !== 64'h4) begin n_bad++; $display("FAIL brs_pre: got %b/%h want 1/4", DE_V, DE_NPC); end
      BR_STALL = 1'b1;
      for (int c = 0; c < 2; c++) begin
         cyc();
         n_cmp++; if (DE_V !== 1'b0) begin n_bad++; $display("FAIL brs_bubble[%0d]: got %b want 0", c, DE_V); end
      end
      BR_STALL = 1'b0;
      n_cmp++; if (imem_if.IMEM_REQ_V !== 1'b0) begin n_bad++; $display("FAIL brs_full: got %b want 0", imem_if.IMEM_REQ_V); end
      cyc();
      n_cmp++;
      if (DE_V !== 1'b1 || DE_IR !== mem_word(64'h4) || DE_NPC !== 64'h8) begin
         n_bad++; $display("FAIL brs_i1: got %b %h/%h want 1 %h/8", DE_V, DE_IR, DE_NPC, mem_word(64'h4));
      end
      cyc();
      n_cmp++;
      if (DE_V !== 1'b1 || DE_IR !== mem_word(64'h8) || DE_NPC !== 64'hC) begin
         n_bad++; $display("FAIL brs_i2: got %b %h/%h want 1 %h/c", DE_V, DE_IR, DE_NPC, mem_word(64'h8));
      end
   endtask

   task automatic test_branch();
      do_reset();
      resp_en = 1'b0;
      cyc(); cyc();
      n_cmp++; if (imem_if.IMEM_REQ_V !== 1'b0) begin n_bad++; $display("FAIL br_two_inflight: got %b want 0", imem_if.IMEM_REQ_V); end
      BR_TAKEN = 1'b1;
      BR_TARGET = 64'h103;
      cyc();
      BR_TAKEN = 1'b0;
      resp_en = 1'b1;
      n_cmp++; if (DE_V !== 1'b0) begin n_bad++; $display("FAIL br_kill: got %b want 0", DE_V); end
      n_cmp++;
      if (imem_if.IMEM_ADDR !== 64'h100 || imem_if.IMEM_REQ_V !== 1'b0) begin
         n_bad++; $display("FAIL br_target: got %h req %b want 100/0", imem_if.IMEM_ADDR, imem_if.IMEM_REQ_V);
      end
      cyc();
      n_cmp++;
      if (imem_if.IMEM_ADDR !== 64'h100 || imem_if.IMEM_REQ_V !== 1'b1) begin
         n_bad++; $display("FAIL br_resume: got %h req %b want 100/1", imem_if.IMEM_ADDR, imem_if.IMEM_REQ_V);
      end
      n_cmp++; if (DE_V !== 1'b0) begin n_bad++; $display("FAIL br_drop0: got %b want 0", DE_V); end
      for (int c = 0; c < 2; c++) begin
         cyc();
         n_cmp++; if (DE_V !== 1'b0) begin n_bad++; $display("FAIL br_drop[%0d]: got %b want 0", c + 1, DE_V); end
      end
      cyc();
      n_cmp++;
      if (DE_V !== 1'b1 || DE_IR !== mem_word(64'h100) || DE_NPC !== 64'h104) begin
         n_bad++; $display("FAIL br_first: got %b %h/%h want 1 %h/104", DE_V, DE_IR, DE_NPC, mem_word(64'h100));
      end
   endtask

   task automatic test_trap();
      do_reset();
      cyc(); cyc(); cyc();
      TRAP = 1'b1; BR_TAKEN = 1'b1; MTVEC = 64'h800; BR_TARGET = 64'h200; DE_STALL = 1'b1;
      cyc();
      n_cmp++; if (DE_V !== 1'b0) begin n_bad++; $display("FAIL trap_kill: got %b want 0", DE_V); end
      n_cmp++; if (imem_if.IMEM_ADDR !== 64'h800) begin n_bad++; $display("FAIL trap_pc: got %h want 800", imem_if.IMEM_ADDR); end
      TRAP = 1'b0; BR_TAKEN = 1'b0; DE_STALL = 1'b0;
      #1;
      n_cmp++; if (imem_if.IMEM_REQ_V !== 1'b1) begin n_bad++; $display("FAIL trap_req: got %b want 1", imem_if.IMEM_REQ_V); end
      cyc(); cyc();
      n_cmp++; if (DE_V !== 1'b0) begin n_bad++; $display("FAIL trap_flush: got %b want 0", DE_V); end
      cyc();
      n_cmp++;
      if (DE_V !== 1'b1 || DE_IR !== mem_word(64'h800) || DE_NPC !== 64'h804) begin
         n_bad++; $display("FAIL trap_first: got %b %h/%h want 1 %h/804", DE_V, DE_IR, DE_NPC, mem_word(64'h800));
      end
   endtask

   task automatic test_rdy_low_and_reset();
      do_reset();
      cyc();
      imem_if.IMEM_REQ_RDY = 1'b0;
      for (int c = 0; c < 4; c++) begin
         cyc();
         n_cmp++;
         if (imem_if.IMEM_ADDR !== 64'h4 || imem_if.IMEM_REQ_V !== 1'b1) begin
            n_bad++; $display("FAIL rdy_hold[%0d]: got %h req %b want 4/1", c, imem_if.IMEM_ADDR, imem_if.IMEM_REQ_V);
         end
      end
      imem_if.IMEM_REQ_RDY = 1'b1;
      cyc();
      n_cmp++; if (imem_if.IMEM_ADDR !== 64'h8) begin n_bad++; $display("FAIL rdy_adv: got %h want 8", imem_if.IMEM_ADDR); end
      cyc(); cyc();
      n_cmp++;
      if (DE_V !== 1'b1 || DE_IR !== mem_word(64'h4) || DE_NPC !== 64'h8) begin
         n_bad++; $display("FAIL rdy_i1: got %b %h/%h want 1 %h/8", DE_V, DE_IR, DE_NPC, mem_word(64'h4));
      end
      reset = 1'b1;
      cyc();
      n_cmp++;
      if (DE_V !== 1'b0 || DE_IR !== 32'h0 || DE_NPC !== 64'h0) begin
         n_bad++; $display("FAIL mid_reset_de: got %b %h/%h want 0 0/0", DE_V, DE_IR, DE_NPC);
      end
      n_cmp++;
      if (imem_if.IMEM_ADDR !== RESET_PC || imem_if.IMEM_REQ_V !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset_pc: got %h req %b want %h/0", imem_if.IMEM_ADDR, imem_if.IMEM_REQ_V, RESET_PC);
      end
      reset = 1'b0;
      cyc(); cyc();
      n_cmp++; if (DE_V !== 1'b0) begin n_bad++; $display("FAIL post_reset_v: got %b want 0", DE_V); end
      cyc();
      n_cmp++;
      if (DE_V !== 1'b1 || DE_IR !== mem_word(64'h0) || DE_NPC !== 64'h4) begin
         n_bad++; $display("FAIL post_reset_i0: got %b %h/%h want 1 %h/4", DE_V, DE_IR, DE_NPC, mem_word(64'h0));
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_de_stall();
      test_br_stall();
      test_branch();
      test_trap();
      test_rdy_low_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
